data_bridge: RTL and testbench
==============================

Name: data_bridge

Overview:
Sits directly downstream of the CPU core's data-memory interface (data_raddr/data_re/data_rdata, data_waddr/data_wdata/data_wstrb/data_we). Decodes each access to either the data RAM or a small peripheral register block: LED, switches, and a machine timer with mtime/mtimecmp and a timer interrupt. Read data returns with a fixed one-cycle latency so RAM and peripheral reads look identical to the core.

Parameters:
PERIPH_BASE, 32'hBFAF_0000, base of peripheral window; match on addr[31:16] == PERIPH_BASE[31:16]
TIMER_DIV, 1, mtime increments once every TIMER_DIV clocks (>=1)
LED_W, 16, LED register width (<=32)
SW_W, 16, switch input width (<=32)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_raddr  in  32  core read address
data_re  in  1  core read enable
data_rdata  out  32  read data, valid the cycle after data_re
data_waddr  in  32  core write address
data_wdata  in  32  core write data
data_wstrb  in  4  byte strobes, bit i -> byte i
data_we  in  1  core write enable
ram_raddr  out  32  RAM read address (pass-through)
ram_re  out  1  RAM read enable, only for non-peripheral reads
ram_rdata  in  32  RAM synchronous read data, one cycle after ram_re
ram_waddr  out  32  RAM write address (pass-through)
ram_wdata  out  32  RAM write data (pass-through)
ram_wstrb  out  4  RAM byte strobes (pass-through)
ram_we  out  1  RAM write enable, only for non-peripheral writes
sw_in  in  SW_W  asynchronous switch inputs
led_out  out  LED_W  LED register
timer_irq  out  1  registered (mtime >= mtimecmp)

Behaviour:
- Reset (async, rst_n=0): led_out=0, mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, timer_irq=0, rd_sel=RAM, periph read latch=0, data_rdata=0 while in reset, switch synchroniser=0.
- Decode: is_periph = addr[31:16]==PERIPH_BASE[31:16]. Read and write ports are decoded independently. ram_re = data_re & ~rd_periph; ram_we = data_we & ~wr_periph. Address/data/strobe pass through combinationally.
- Peripheral offsets (addr[11:0]); other addresses in the window read 0 and ignore writes:
  0x000 LED RW; 0x004 SW RO (synchronised value, zero-extended); 0x010 MTIME_LO; 0x014 MTIME_HI; 0x018 MTIMECMP_LO; 0x01C MTIMECMP_HI.
- Read path, 1-cycle latency: when data_re=1 at edge N, register rd_sel (RAM/PERIPH) and, if PERIPH, latch the peripheral word. In cycle N+1, data_rdata = rd_sel ? latched word : ram_rdata. When data_re=0, rd_sel and the latch hold their values (data_rdata is don't-care to the core).
- Write path: peripheral writes take effect at the clock edge. Only lanes with data_wstrb[i]=1 are updated. LED register bits above LED_W are discarded.
- Same-cycle read and write to the same peripheral register: the read returns the pre-write value.
- Timer: the prescaler counts 0..TIMER_DIV-1; mtime += 1 (64-bit, wraps at 2^64 to 0) when prescaler==TIMER_DIV-1. A write to MTIME_LO/HI in the same cycle overrides the increment for the whole 64-bit value: the written lanes take the new data, unwritten lanes keep their pre-increment value. The prescaler does not reset on a mtime write.
- Write ordering: the LO word is written first, with no hardware carry protection; software handles the LO/HI tear.
- timer_irq: registered each cycle from the current mtime >= mtimecmp, unsigned 64-bit compare, so it lags by 1 cycle. It is level, and clears when mtimecmp is written above mtime.
- sw_in: passes through a 2-flop synchroniser; SW reads see the second flop.
- Reset mid-operation: any in-flight read returns 0 on data_rdata while rst_n=0. No pending state survives reset.

Test Plan:
- Reset, then read 0x0000_1000 with ram_rdata=32'hCAFE_F00D the following cycle -> ram_re=1 that cycle; data_rdata=32'hCAFE_F00D the next cycle.
- Write 0xBFAF_0000 data=32'h1234_ABCD strb=4'b0001 after reset -> led_out=16'h00CD, ram_we=0. Then strb=4'b0011 -> led_out=16'hABCD.
- sw_in=16'h5A5A held 3 cycles, then read 0xBFAF_0004 -> data_rdata=32'h0000_5A5A one cycle after re; ram_re=0.
- TIMER_DIV=1: write MTIMECMP_HI=0 then MTIMECMP_LO=20 (full strobes) -> timer_irq rises 1 cycle after mtime reaches 20. Writing MTIMECMP_LO=32'hFFFF_FFFF clears it the cycle after mtime is next sampled below it.
- Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=0 -> after the next increment, reading MTIME_HI returns 1 and MTIME_LO returns 0 (carry). A write concurrent with an increment holds the written value.
- Read and write LED in the same cycle, old=16'h0001, new=16'h00FF -> data_rdata=32'h1, then led_out=16'h00FF. Assert rst_n low mid-read -> data_rdata=0, led_out=0, mtimecmp all-ones.

Source files
------------

// File: rtl/data_bridge_if.sv
// data_bridge_if: the core-side data-memory bus and the RAM-side bus that
// data_bridge sits between.
//   data_*  : core read port (raddr/re/rdata) and write port
//             (waddr/wdata/wstrb/we)
//   ram_*   : the same signals forwarded to the data RAM, plus the RAM's
//             synchronous read data
// modport slave  : the bridge's view
// modport master : the environment's view (core + RAM)
interface data_bridge_if;
  logic [31:0] data_raddr;
  logic        data_re;
  logic [31:0] data_rdata;
  logic [31:0] data_waddr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_we;
  logic [31:0] ram_raddr;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic        ram_we;

  modport slave (
    input  data_raddr, data_re, data_waddr, data_wdata, data_wstrb, data_we,
    input  ram_rdata,
    output data_rdata,
    output ram_raddr, ram_re, ram_waddr, ram_wdata, ram_wstrb, ram_we
  );

  modport master (
    output data_raddr, data_re, data_waddr, data_wdata, data_wstrb, data_we,
    output ram_rdata,
    input  data_rdata,
    input  ram_raddr, ram_re, ram_waddr, ram_wdata, ram_wstrb, ram_we
  );
endinterface

// File: rtl/data_bridge.sv
// data_bridge: decodes core data accesses to either the data RAM or a small
// peripheral block (LED, switches, machine timer). Reads have a fixed one-cycle
// latency for both targets.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : data_bridge_if.slave (core bus in, RAM bus out)
//   sw_in      : asynchronous switch inputs (synchronised internally)
//   led_out    : LED register
//   timer_irq  : registered (mtime >= mtimecmp), level
module data_bridge #(
  parameter logic [31:0] PERIPH_BASE = 32'hBFAF_0000,
  parameter int unsigned TIMER_DIV   = 1,
  parameter int unsigned LED_W       = 16,
  parameter int unsigned SW_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  data_bridge_if.slave     bus,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             timer_irq
);

  localparam logic [15:0] BASE_HI      = PERIPH_BASE[31:16];
  localparam logic [31:0] DIV_LAST     = 32'(TIMER_DIV - 1);
  localparam logic [11:0] OFF_LED      = 12'h000;
  localparam logic [11:0] OFF_SW       = 12'h004;
  localparam logic [11:0] OFF_MTIME_LO = 12'h010;
  localparam logic [11:0] OFF_MTIME_HI = 12'h014;
  localparam logic [11:0] OFF_CMP_LO   = 12'h018;
  localparam logic [11:0] OFF_CMP_HI   = 12'h01C;

  // Byte-lane merge: strobed lanes take new data, others keep old data.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [LED_W-1:0] led_q, led_d;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic [31:0]      presc_q, presc_d;
  logic             irq_q, irq_d;
  logic             rd_sel_q, rd_sel_d;
  logic [31:0]      rd_word_q, rd_word_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;

  logic             rd_periph_s, wr_periph_s, tick_s;
  logic [31:0]      led_ext_s, sw_ext_s, periph_rword_s, led_merge_s;
  logic             unused_bits_s;

  assign rd_periph_s = (bus.data_raddr[31:16] == BASE_HI);
  assign wr_periph_s = (bus.data_waddr[31:16] == BASE_HI);

  assign bus.ram_raddr = bus.data_raddr;
  assign bus.ram_re    = bus.data_re & ~rd_periph_s;
  assign bus.ram_waddr = bus.data_waddr;
  assign bus.ram_wdata = bus.data_wdata;
  assign bus.ram_wstrb = bus.data_wstrb;
  assign bus.ram_we    = bus.data_we & ~wr_periph_s;

  assign led_out   = led_q;
  assign timer_irq = irq_q;

  // Address bits 15:12 are not part of the register decode.
  assign unused_bits_s = ^{bus.data_raddr[15:12], bus.data_waddr[15:12], led_merge_s};

  // Zero-extend the LED register and the synchronised switches to 32 bits.
  always_comb begin
    led_ext_s = 32'h0;
    led_ext_s[LED_W-1:0] = led_q;
    sw_ext_s = 32'h0;
    sw_ext_s[SW_W-1:0] = sw_sync_q;
  end

  // Peripheral read mux on the current (pre-write) register values.
  always_comb begin
    case (bus.data_raddr[11:0])
      OFF_LED:      periph_rword_s = led_ext_s;
      OFF_SW:       periph_rword_s = sw_ext_s;
      OFF_MTIME_LO: periph_rword_s = mtime_q[31:0];
      OFF_MTIME_HI: periph_rword_s = mtime_q[63:32];
      OFF_CMP_LO:   periph_rword_s = mtimecmp_q[31:0];
      OFF_CMP_HI:   periph_rword_s = mtimecmp_q[63:32];
      default:      periph_rword_s = 32'h0;
    endcase
  end

  // Read data: RAM data passes straight through; peripheral data comes from
  // the latch; forced to zero while in reset so an in-flight read returns 0.
  always_comb begin
    if (!rst_n) begin
      bus.data_rdata = 32'h0;
    end else if (rd_sel_q) begin
      bus.data_rdata = rd_word_q;
    end else begin
      bus.data_rdata = bus.ram_rdata;
    end
  end

  // Next-state for timer, LED, compare register and the read latch.
  always_comb begin
    tick_s      = (presc_q == DIV_LAST);
    presc_d     = tick_s ? 32'h0 : presc_q + 32'h1;
    mtime_d     = mtime_q + {63'h0, tick_s};
    mtimecmp_d  = mtimecmp_q;
    led_d       = led_q;
    led_merge_s = lane_merge(led_ext_s, bus.data_wdata, bus.data_wstrb);
    irq_d       = (mtime_q >= mtimecmp_q);
    if (bus.data_we && wr_periph_s) begin
      // An mtime write replaces the increment for the whole 64-bit value.
      case (bus.data_waddr[11:0])
        OFF_LED:      led_d = led_merge_s[LED_W-1:0];
        OFF_MTIME_LO: mtime_d = {mtime_q[63:32],
                                 lane_merge(mtime_q[31:0], bus.data_wdata, bus.data_wstrb)};
        OFF_MTIME_HI: mtime_d = {lane_merge(mtime_q[63:32], bus.data_wdata, bus.data_wstrb),
                                 mtime_q[31:0]};
        OFF_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32],
                                    lane_merge(mtimecmp_q[31:0], bus.data_wdata, bus.data_wstrb)};
        OFF_CMP_HI:   mtimecmp_d = {lane_merge(mtimecmp_q[63:32], bus.data_wdata, bus.data_wstrb),
                                    mtimecmp_q[31:0]};
        default:      led_d = led_q;
      endcase
    end else begin
      led_d = led_q;
    end
    rd_sel_d  = rd_sel_q;
    rd_word_d = rd_word_q;
    if (bus.data_re) begin
      rd_sel_d = rd_periph_s;
      if (rd_periph_s) begin
        rd_word_d = periph_rword_s;
      end else begin
        rd_word_d = rd_word_q;
      end
    end else begin
      rd_sel_d = rd_sel_q;
    end
  end

  // State registers, including the two-flop switch synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc_q    <= 32'h0;
      irq_q      <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_word_q  <= 32'h0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      led_q      <= led_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      irq_q      <= irq_d;
      rd_sel_q   <= rd_sel_d;
      rd_word_q  <= rd_word_d;
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
    end
  end

endmodule

// File: tb/tb_data_bridge.sv
// Self-checking bench for data_bridge: directed scenarios plus randomized
// traffic, all compared against a register-level reference model.
module tb_data_bridge;
  localparam logic [31:0] PB  = 32'hBFAF_0000;
  localparam int          DIV = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw_in = 16'h0;
  logic [15:0] led_out;
  logic        timer_irq;
  int          n_checks = 0;
  int          n_fail = 0;

  data_bridge_if bif();

  data_bridge #(.PERIPH_BASE(PB), .TIMER_DIV(DIV), .LED_W(16), .SW_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif), .sw_in(sw_in),
    .led_out(led_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register values.
  logic [31:0] m_led, m_sw1, m_sw2, m_rword;
  logic [63:0] m_mtime, m_cmp;
  logic        m_irq, m_rsel;
  int          m_presc;

  task automatic model_reset();
    m_led = 32'h0; m_mtime = 64'h0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_irq = 1'b0; m_presc = 0; m_sw1 = 32'h0; m_sw2 = 32'h0;
    m_rsel = 1'b0; m_rword = 32'h0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_reg(input logic [11:0] off);
    case (off)
      12'h000: return m_led;
      12'h004: return m_sw2;
      12'h010: return m_mtime[31:0];
      12'h014: return m_mtime[63:32];
      12'h018: return m_cmp[31:0];
      12'h01C: return m_cmp[63:32];
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock: compute the model's next state from the inputs now
  // applied, then let the edge happen and settle.
  task automatic step();
    logic        rp, wp, n_irq, n_rsel;
    logic [31:0] n_led, n_rword, n_sw1, n_sw2, wd;
    logic [63:0] n_mtime, n_cmp;
    int          n_presc;
    logic [3:0]  st;
    rp = (bif.data_raddr[31:16] == PB[31:16]);
    wp = (bif.data_waddr[31:16] == PB[31:16]);
    wd = bif.data_wdata; st = bif.data_wstrb;
    n_presc = (m_presc == DIV - 1) ? 0 : m_presc + 1;
    n_mtime = m_mtime + ((m_presc == DIV - 1) ? 64'd1 : 64'd0);
    n_irq = (m_mtime >= m_cmp);
    n_led = m_led; n_cmp = m_cmp;
    if (bif.data_we && wp) begin
      case (bif.data_waddr[11:0])
        12'h000: n_led = merge(m_led, wd, st) & 32'h0000_FFFF;
        12'h010: n_mtime = {m_mtime[63:32], merge(m_mtime[31:0], wd, st)};
        12'h014: n_mtime = {merge(m_mtime[63:32], wd, st), m_mtime[31:0]};
        12'h018: n_cmp = {m_cmp[63:32], merge(m_cmp[31:0], wd, st)};
        12'h01C: n_cmp = {merge(m_cmp[63:32], wd, st), m_cmp[31:0]};
        default: ;
      endcase
    end
    n_rsel = m_rsel; n_rword = m_rword;
    if (bif.data_re) begin
      n_rsel = rp;
      if (rp) n_rword = m_reg(bif.data_raddr[11:0]);
    end
    n_sw1 = {16'h0, sw_in}; n_sw2 = m_sw1;
    @(posedge clk); #1;
    m_led = n_led; m_mtime = n_mtime; m_cmp = n_cmp; m_irq = n_irq; m_presc = n_presc;
    m_rsel = n_rsel; m_rword = n_rword; m_sw1 = n_sw1; m_sw2 = n_sw2;
  endtask

  task automatic idle();
    bif.data_re = 1'b0; bif.data_we = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bif.data_we = 1'b1; bif.data_waddr = a; bif.data_wdata = d; bif.data_wstrb = s;
    step();
    bif.data_we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    bif.data_re = 1'b1; bif.data_raddr = a;
    step();
    bif.data_re = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    bif.ram_rdata = 32'hDEAD_BEEF;
    bif.data_raddr = 32'h0; bif.data_waddr = 32'h0;
    bif.data_wdata = 32'h0; bif.data_wstrb = 4'h0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (bif.data_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", bif.data_rdata, 32'h0); end
    n_checks++; if (led_out !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h want %h", led_out, 16'h0); end
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_ram_read();
    bif.data_re = 1'b1; bif.data_raddr = 32'h0000_1000;
    #1;
    n_checks++; if (bif.ram_re !== 1'b1 || bif.ram_raddr !== 32'h0000_1000) begin n_fail++; $display("FAIL ram_re: got re=%b addr=%h want re=1 addr=00001000", bif.ram_re, bif.ram_raddr); end
    step();
    bif.data_re = 1'b0; bif.ram_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if (bif.data_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_rdata: got %h want cafef00d", bif.data_rdata); end
  endtask

  task automatic test_led_write();
    bif.data_we = 1'b1; bif.data_waddr = PB; bif.data_wdata = 32'h1234_ABCD; bif.data_wstrb = 4'b0001;
    #1;
    n_checks++; if (bif.ram_we !== 1'b0) begin n_fail++; $display("FAIL led_ram_we: got %b want 0", bif.ram_we); end
    step();
    n_checks++; if (led_out !== 16'h00CD) begin n_fail++; $display("FAIL led_lane0: got %h want 00cd", led_out); end
    do_write(PB, 32'h1234_ABCD, 4'b0011);
    n_checks++; if (led_out !== 16'hABCD) begin n_fail++; $display("FAIL led_lane01: got %h want abcd", led_out); end
  endtask

  task automatic test_sw_read();
    sw_in = 16'h5A5A;
    repeat (3) step();
    bif.data_re = 1'b1; bif.data_raddr = PB | 32'h4;
    #1;
    n_checks++; if (bif.ram_re !== 1'b0) begin n_fail++; $display("FAIL sw_ram_re: got %b want 0", bif.ram_re); end
    step();
    bif.data_re = 1'b0;
    n_checks++; if (bif.data_rdata !== 32'h0000_5A5A) begin n_fail++; $display("FAIL sw_read: got %h want 00005a5a", bif.data_rdata); end
  endtask

  task automatic test_rw_same_cycle();
    do_write(PB, 32'h0000_0001, 4'b1111);
    bif.data_re = 1'b1; bif.data_raddr = PB;
    do_write(PB, 32'h0000_00FF, 4'b1111);
    bif.data_re = 1'b0;
    n_checks++; if (bif.data_rdata !== 32'h1) begin n_fail++; $display("FAIL rw_old_value: got %h want 00000001", bif.data_rdata); end
    n_checks++; if (led_out !== 16'h00FF) begin n_fail++; $display("FAIL rw_new_led: got %h want 00ff", led_out); end
  endtask

  task automatic test_timer_irq();
    int rise_at;
    rise_at = -1;
    do_write(PB | 32'h10, 32'h0, 4'b1111);
    do_write(PB | 32'h14, 32'h0, 4'b1111);
    do_write(PB | 32'h1C, 32'h0, 4'b1111);
    do_write(PB | 32'h18, 32'd20, 4'b1111);
    // mtime is 2 here; it reaches 20 after 18 more edges, irq one edge later.
    for (int i = 1; i <= 40; i++) begin
      step();
      n_checks++; if (timer_irq !== m_irq) begin n_fail++; $display("FAIL irq_track: cycle %0d got %b want %b", i, timer_irq, m_irq); end
      if (timer_irq === 1'b1 && rise_at < 0) rise_at = i;
    end
    n_checks++; if (rise_at != 19) begin n_fail++; $display("FAIL irq_rise_cycle: got %0d want 19", rise_at); end
    do_write(PB | 32'h18, 32'hFFFF_FFFF, 4'b1111);
    n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_lag: got %b want 1", timer_irq); end
    step();
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", timer_irq); end
  endtask

  task automatic test_mtime_carry();
    do_write(PB | 32'h10, 32'hFFFF_FFFF, 4'b1111);
    do_write(PB | 32'h14, 32'h0, 4'b1111);
    step();
    do_read(PB | 32'h10);
    n_checks++; if (bif.data_rdata !== 32'h0) begin n_fail++; $display("FAIL carry_lo: got %h want 00000000", bif.data_rdata); end
    do_read(PB | 32'h14);
    n_checks++; if (bif.data_rdata !== 32'h1) begin n_fail++; $display("FAIL carry_hi: got %h want 00000001", bif.data_rdata); end
    do_write(PB | 32'h10, 32'h0000_1000, 4'b1111);
    do_read(PB | 32'h10);
    n_checks++; if (bif.data_rdata !== 32'h0000_1000) begin n_fail++; $display("FAIL write_holds: got %h want 00001000", bif.data_rdata); end
    do_write(PB | 32'h14, 32'hAABB_CCDD, 4'b0100);
    do_read(PB | 32'h14);
    n_checks++; if (bif.data_rdata !== m_rword || bif.data_rdata !== 32'h00BB_0001) begin n_fail++; $display("FAIL partial_hi: got %h want 00bb0001", bif.data_rdata); end
  endtask

  task automatic test_random();
    logic [11:0] offs [8];
    logic        rp, wp, exp_re, exp_we;
    logic [31:0] exp_rd;
    offs = '{12'h000, 12'h004, 12'h010, 12'h014, 12'h018, 12'h01C, 12'h020, 12'h008};
    for (int i = 0; i < 300; i++) begin
      rp = ($urandom_range(0, 2) != 0); wp = ($urandom_range(0, 2) != 0);
      bif.data_re = 1'($urandom); bif.data_we = 1'($urandom);
      bif.data_raddr = rp ? {PB[31:16], 4'h0, offs[$urandom_range(0, 7)]} : {16'h0001, 16'($urandom)};
      bif.data_waddr = wp ? {PB[31:16], 4'h0, offs[$urandom_range(0, 5)]} : {16'h0002, 16'($urandom)};
      // Keep mtimecmp near mtime so the interrupt toggles.
      bif.data_wdata = (bif.data_waddr[11:0] == 12'h018) ? m_mtime[31:0] + 32'($urandom_range(0, 6)) - 32'd3 :
                       (bif.data_waddr[11:0] == 12'h01C) ? m_mtime[63:32] : $urandom;
      bif.data_wstrb = 4'($urandom);
      sw_in = 16'($urandom);
      #1;
      exp_re = bif.data_re & ~rp; exp_we = bif.data_we & ~wp;
      n_checks++; if (bif.ram_re !== exp_re || bif.ram_we !== exp_we) begin n_fail++; $display("FAIL rnd_decode: it %0d got re=%b we=%b want re=%b we=%b", i, bif.ram_re, bif.ram_we, exp_re, exp_we); end
      step();
      bif.ram_rdata = $urandom;
      #1;
      exp_rd = m_rsel ? m_rword : bif.ram_rdata;
      n_checks++; if (bif.data_rdata !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata: it %0d got %h want %h", i, bif.data_rdata, exp_rd); end
      n_checks++; if (led_out !== m_led[15:0] || timer_irq !== m_irq) begin n_fail++; $display("FAIL rnd_state: it %0d got led=%h irq=%b want led=%h irq=%b", i, led_out, timer_irq, m_led[15:0], m_irq); end
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    do_write(PB, 32'h0000_0055, 4'b1111);
    do_write(PB | 32'h18, 32'h0, 4'b1111);
    do_read(PB);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bif.data_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rdata: got %h want 00000000", bif.data_rdata); end
    n_checks++; if (led_out !== 16'h0 || timer_irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state: got led=%h irq=%b want 0000/0", led_out, timer_irq); end
    #2 rst_n = 1'b1;
    model_reset();
    do_read(PB | 32'h18);
    n_checks++; if (bif.data_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cmp_lo_reset: got %h want ffffffff", bif.data_rdata); end
    do_read(PB | 32'h1C);
    n_checks++; if (bif.data_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cmp_hi_reset: got %h want ffffffff", bif.data_rdata); end
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_led_write();
    test_sw_read();
    test_rw_same_cycle();
    test_timer_irq();
    test_mtime_carry();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
